// File: rtl/gfx_pkg.sv
// Shared vertex/triangle types and cull-mode constants for the geometry front end.
package gfx_pkg;

    localparam int VTX_W = 9;

    localparam int CULL_NONE  = 0;
    localparam int CULL_DEGEN = 1;
    localparam int CULL_BACK  = 2;

    typedef struct packed {
        logic [VTX_W-1:0] x;
        logic [VTX_W-1:0] y;
        logic [VTX_W-1:0] z;
    } vertex_t;

    // Index 0 is the first vertex received, index 2 the last.
    typedef vertex_t [2:0] tri_t;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_DONE    = 2'd2
    } asm_state_e;

endpackage

// File: rtl/tri_assembler_if.sv
// Vertex stream in from tri_proj and triangle stream out to the rasterizer.
interface tri_assembler_if;
    import gfx_pkg::*;

    logic                    valid_in;
    logic [VTX_W-1:0]        x_in;
    logic [VTX_W-1:0]        y_in;
    logic [VTX_W-1:0]        z_in;
    logic                    obj_done_in;
    logic                    tri_ready_in;

    logic [2:0][VTX_W-1:0]   vert1_out;
    logic [2:0][VTX_W-1:0]   vert2_out;
    logic [2:0][VTX_W-1:0]   vert3_out;
    logic                    valid_tri_out;
    logic                    obj_done_out;
    logic                    overflow_out;
    logic                    partial_out;
    logic [15:0]             tri_count_out;

    modport slave (
        input  valid_in, x_in, y_in, z_in, obj_done_in, tri_ready_in,
        output vert1_out, vert2_out, vert3_out, valid_tri_out,
               obj_done_out, overflow_out, partial_out, tri_count_out
    );

    modport master (
        output valid_in, x_in, y_in, z_in, obj_done_in, tri_ready_in,
        input  vert1_out, vert2_out, vert3_out, valid_tri_out,
               obj_done_out, overflow_out, partial_out, tri_count_out
    );

endinterface

// File: rtl/tri_fifo.sv
// First-word-fall-through triangle FIFO; a write into a full FIFO succeeds only
// when a read frees a slot in the same cycle.
module tri_fifo
    import gfx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic wr_en_i,
    input  tri_t wr_data_i,
    output logic wr_ok_o,
    input  logic rd_en_i,
    output tri_t rd_data_o,
    output logic full_o,
    output logic empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    tri_t          mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_rd;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == FULL_CNT);
    assign do_rd   = rd_en_i && !empty_o;
    assign wr_ok_o = wr_en_i && (!full_o || do_rd);

    // The head reads as zero when empty so idle outputs never show stale data.
    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_ok_o) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_rd)   rd_ptr_d = rd_ptr_q + AW'(1);
        cnt_d = cnt_q + (AW+1)'(wr_ok_o) - (AW+1)'(do_rd);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_ok_o) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/tri_assembler.sv
// Groups projected vertices into triangles, culls them by signed screen area and
// queues survivors for the rasterizer; end-of-object is released once all drains.
module tri_assembler
    import gfx_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int CULL_MODE = 1
) (
    input  logic           clk_in,
    input  logic           rst_in,
    tri_assembler_if.slave bus
);

    function automatic logic signed [9:0] vdiff(input logic [VTX_W-1:0] a,
                                                input logic [VTX_W-1:0] b);
        return $signed({1'b0, a}) - $signed({1'b0, b});
    endfunction

    vertex_t            vtx_in;
    vertex_t            slot_q [2];
    logic [1:0]         v_idx_q, v_idx_d;
    logic               tri_done;
    tri_t               new_tri;

    logic               s1_vld_q;
    tri_t               s1_tri_q;
    logic signed [9:0]  s1_dx2_q, s1_dy2_q, s1_dx3_q, s1_dy3_q;
    logic               s2_vld_q;
    tri_t               s2_tri_q;
    logic signed [20:0] s2_area_q, area_d;
    logic               keep;

    logic               wr_en, wr_ok, pop, fifo_full, fifo_empty;
    tri_t               head;

    asm_state_e         state_q, state_d;
    logic               pend_q, pend_d;
    logic               partial_q, partial_d;
    logic               overflow_q, overflow_d;
    logic [15:0]        cnt_q, cnt_d;

    assign vtx_in   = {bus.x_in, bus.y_in, bus.z_in};
    assign tri_done = bus.valid_in && (v_idx_q == 2'd2);
    assign new_tri  = {vtx_in, slot_q[1], slot_q[0]};

    always_ff @(posedge clk_in) begin
        if (bus.valid_in && (v_idx_q != 2'd2)) slot_q[v_idx_q[0]] <= vtx_in;
    end

    // S1: edge vectors relative to the first vertex
    always_ff @(posedge clk_in) begin
        if (tri_done) begin
            s1_tri_q <= new_tri;
            s1_dx2_q <= vdiff(slot_q[1].x, slot_q[0].x);
            s1_dy2_q <= vdiff(slot_q[1].y, slot_q[0].y);
            s1_dx3_q <= vdiff(vtx_in.x, slot_q[0].x);
            s1_dy3_q <= vdiff(vtx_in.y, slot_q[0].y);
        end
    end

    // S2: twice the signed area; positive means counter-clockwise
    assign area_d = 21'(s1_dx2_q) * 21'(s1_dy3_q) - 21'(s1_dy2_q) * 21'(s1_dx3_q);

    always_ff @(posedge clk_in) begin
        if (s1_vld_q) begin
            s2_tri_q  <= s1_tri_q;
            s2_area_q <= area_d;
        end
    end

    always_comb begin
        keep = 1'b1;
        if (CULL_MODE == CULL_DEGEN)     keep = (s2_area_q != '0);
        else if (CULL_MODE == CULL_BACK) keep = (s2_area_q > 0);
    end

    assign wr_en = s2_vld_q && keep;
    assign pop   = bus.tri_ready_in && !fifo_empty;

    tri_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i     (clk_in),
        .rst_i     (rst_in),
        .wr_en_i   (wr_en),
        .wr_data_i (s2_tri_q),
        .wr_ok_o   (wr_ok),
        .rd_en_i   (pop),
        .rd_data_o (head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    always_comb begin
        v_idx_d    = v_idx_q;
        state_d    = state_q;
        pend_d     = pend_q;
        partial_d  = partial_q;
        overflow_d = overflow_q | (wr_en && fifo_full && !pop);
        cnt_d      = cnt_q + 16'(wr_ok);

        if (bus.valid_in) v_idx_d = (v_idx_q == 2'd2) ? 2'd0 : v_idx_q + 2'd1;

        case (state_q)
            ST_COLLECT: begin
                if (bus.obj_done_in || pend_q) begin
                    state_d = ST_FLUSH;
                    pend_d  = 1'b0;
                    // An incomplete triangle at end-of-object is thrown away.
                    if (v_idx_d != 2'd0) begin
                        v_idx_d   = 2'd0;
                        partial_d = 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                if (bus.obj_done_in) pend_d = 1'b1;
                if (!s1_vld_q && !s2_vld_q && fifo_empty) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (bus.obj_done_in) pend_d = 1'b1;
                state_d = ST_COLLECT;
                cnt_d   = 16'(wr_ok);
            end
            default: state_d = ST_COLLECT;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            v_idx_q    <= 2'd0;
            s1_vld_q   <= 1'b0;
            s2_vld_q   <= 1'b0;
            state_q    <= ST_COLLECT;
            pend_q     <= 1'b0;
            partial_q  <= 1'b0;
            overflow_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            v_idx_q    <= v_idx_d;
            s1_vld_q   <= tri_done;
            s2_vld_q   <= s1_vld_q;
            state_q    <= state_d;
            pend_q     <= pend_d;
            partial_q  <= partial_d;
            overflow_q <= overflow_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.vert1_out     = head[0];
    assign bus.vert2_out     = head[1];
    assign bus.vert3_out     = head[2];
    assign bus.valid_tri_out = !fifo_empty;
    assign bus.obj_done_out  = (state_q == ST_DONE);
    assign bus.overflow_out  = overflow_q;
    assign bus.partial_out   = partial_q;
    assign bus.tri_count_out = cnt_q;

endmodule

// File: tb/tb_tri_assembler.sv
// Drives one vertex stream into three assemblers (no cull, degenerate cull, back cull)
// and compares each against a queue-and-timestamp model of the triangle flow.
module tb_tri_assembler;
    import gfx_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst, valid, od, rdy;
    logic [8:0] xi, yi, zi;

    always #5 clk = ~clk;

    logic [2:0]        o_vld, o_done, o_ovf, o_part;
    logic [2:0][80:0]  o_tri;
    logic [2:0][15:0]  o_cnt;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        tri_assembler_if bus_if ();
        assign bus_if.valid_in     = valid;
        assign bus_if.x_in         = xi;
        assign bus_if.y_in         = yi;
        assign bus_if.z_in         = zi;
        assign bus_if.obj_done_in  = od;
        assign bus_if.tri_ready_in = rdy;

        tri_assembler #(.DEPTH(DEPTH), .CULL_MODE(g)) u_dut (
            .clk_in (clk),
            .rst_in (rst),
            .bus    (bus_if)
        );

        assign o_vld[g]  = bus_if.valid_tri_out;
        assign o_tri[g]  = {bus_if.vert3_out, bus_if.vert2_out, bus_if.vert1_out};
        assign o_done[g] = bus_if.obj_done_out;
        assign o_ovf[g]  = bus_if.overflow_out;
        assign o_part[g] = bus_if.partial_out;
        assign o_cnt[g]  = bus_if.tri_count_out;
    end

    // Reference model: FIFO contents, triangles in flight with their write times,
    // pending vertices, object phase (0 collecting, 1 draining, 2 announcing done).
    logic [80:0] mf      [3][DEPTH];
    int          mhead   [3];
    int          mcnt    [3];
    int          mtc     [3];
    int          mph     [3];
    bit          movf    [3];
    bit          mpart   [3];
    bit          mpend   [3];
    logic [26:0] vb      [3][2];
    int          vn      [3];
    logic [80:0] inf_tri [3][4];
    int          inf_due [3][4];
    int          inf_n   [3];
    int          cyc = 0;

    function automatic bit keep_ref(input int mode, input logic [80:0] t);
        int x1, y1, x2, y2, x3, y3, a;
        x1 = int'(t[26:18]); y1 = int'(t[17:9]);
        x2 = int'(t[53:45]); y2 = int'(t[44:36]);
        x3 = int'(t[80:72]); y3 = int'(t[71:63]);
        a = (x2 - x1) * (y3 - y1) - (y2 - y1) * (x3 - x1);
        if (mode == 0) return 1'b1;
        if (mode == 1) return a != 0;
        return a > 0;
    endfunction

    task automatic model_step(input int m);
        bit pipe_empty, fifo_was_empty, wrote;
        logic [80:0] t;
        pipe_empty     = (inf_n[m] == 0);
        fifo_was_empty = (mcnt[m] == 0);
        wrote          = 1'b0;
        if (!fifo_was_empty && rdy) begin
            mhead[m] = (mhead[m] + 1) % DEPTH;
            mcnt[m]--;
        end
        if (inf_n[m] > 0 && inf_due[m][0] == cyc) begin
            t = inf_tri[m][0];
            for (int i = 0; i < 3; i++) begin
                inf_tri[m][i] = inf_tri[m][i+1];
                inf_due[m][i] = inf_due[m][i+1];
            end
            inf_n[m]--;
            if (keep_ref(m, t)) begin
                if (mcnt[m] < DEPTH) begin
                    mf[m][(mhead[m] + mcnt[m]) % DEPTH] = t;
                    mcnt[m]++;
                    mtc[m] = (mtc[m] + 1) % 65536;
                    wrote  = 1'b1;
                end else begin
                    movf[m] = 1'b1;
                end
            end
        end
        if (valid) begin
            if (vn[m] == 2) begin
                inf_tri[m][inf_n[m]] = {xi, yi, zi, vb[m][1], vb[m][0]};
                inf_due[m][inf_n[m]] = cyc + 2;
                inf_n[m]++;
                vn[m] = 0;
            end else begin
                vb[m][vn[m]] = {xi, yi, zi};
                vn[m]++;
            end
        end
        case (mph[m])
            0: if (od || mpend[m]) begin
                mph[m]   = 1;
                mpend[m] = 1'b0;
                if (vn[m] != 0) begin
                    vn[m]    = 0;
                    mpart[m] = 1'b1;
                end
            end
            1: begin
                if (od) mpend[m] = 1'b1;
                if (pipe_empty && fifo_was_empty) mph[m] = 2;
            end
            default: begin
                if (od) mpend[m] = 1'b1;
                mph[m] = 0;
                mtc[m] = wrote ? 1 : 0;
            end
        endcase
    endtask

    always @(posedge clk) begin
        if (rst) begin
            for (int m = 0; m < 3; m++) begin
                mhead[m] = 0; mcnt[m] = 0; mtc[m] = 0; mph[m] = 0;
                vn[m] = 0; inf_n[m] = 0;
                movf[m] = 1'b0; mpart[m] = 1'b0; mpend[m] = 1'b0;
            end
        end else begin
            for (int m = 0; m < 3; m++) model_step(m);
        end
        cyc++;
    end

    task automatic chk(input string tag, input int m, input logic [80:0] got, input logic [80:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, m, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            for (int m = 0; m < 3; m++) begin
                logic [80:0] exp_t;
                exp_t = (mcnt[m] > 0) ? mf[m][mhead[m]] : '0;
                chk("valid_tri", m, 81'(o_vld[m]), 81'(mcnt[m] > 0));
                chk("verts",     m, o_tri[m], exp_t);
                chk("tri_count", m, 81'(o_cnt[m]), 81'(mtc[m]));
                chk("overflow",  m, 81'(o_ovf[m]), 81'(movf[m]));
                chk("partial",   m, 81'(o_part[m]), 81'(mpart[m]));
                chk("obj_done",  m, 81'(o_done[m]), 81'(mph[m] == 2));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic vtx(input int x, input int y, input int z);
        valid = 1'b1; xi = 9'(x); yi = 9'(y); zi = 9'(z);
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic obj_end();
        od = 1'b1;
        @(negedge clk);
        od = 1'b0;
    endtask

    initial begin
        int pulses;
        valid = 1'b0; od = 1'b0; rdy = 1'b0; xi = '0; yi = '0; zi = '0;
        rst = 1'b1;
        idle(2);
        chk_on = 1'b1;
        rst = 1'b0;
        for (int m = 0; m < 3; m++) begin
            chk("rst_valid", m, 81'(o_vld[m]), 81'(0));
            chk("rst_count", m, 81'(o_cnt[m]), 81'(0));
            chk("rst_verts", m, o_tri[m], 81'(0));
        end

        // Basic triangle, latency and end-of-object
        rdy = 1'b1;
        vtx(20, 20, 30); vtx(20, 40, 30); vtx(40, 20, 30);
        idle(1);
        chk("lat_early", 1, 81'(o_vld[1]), 81'(0));
        idle(1);
        chk("lat_n3", 1, 81'(o_vld[1]), 81'(1));
        chk("vert1", 1, 81'(o_tri[1][26:0]), 81'({9'd20, 9'd20, 9'd30}));
        chk("count1", 1, 81'(o_cnt[1]), 81'(1));
        obj_end();
        pulses = 0;
        repeat (8) begin
            if (o_done[1]) pulses++;
            @(negedge clk);
        end
        chk("done_once", 1, 81'(pulses), 81'(1));
        chk("count_clr", 1, 81'(o_cnt[1]), 81'(0));

        // Collinear triangle
        vtx(0, 0, 0); vtx(10, 10, 0); vtx(20, 20, 0);
        idle(4);
        chk("collinear_m1", 1, 81'(o_cnt[1]), 81'(0));
        chk("collinear_m0", 0, 81'(o_cnt[0]), 81'(1));
        obj_end(); idle(6);

        // Winding order
        vtx(0, 0, 0); vtx(0, 10, 0); vtx(10, 0, 0);
        idle(4);
        chk("cw_m2", 2, 81'(o_cnt[2]), 81'(0));
        vtx(0, 0, 0); vtx(10, 0, 0); vtx(0, 10, 0);
        idle(4);
        chk("ccw_m2", 2, 81'(o_cnt[2]), 81'(1));
        chk("both_m1", 1, 81'(o_cnt[1]), 81'(2));
        obj_end(); idle(6);

        // Overflow with the rasterizer stalled
        rdy = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            vtx(0, 0, k); vtx(10, 0, k); vtx(0, 10, k);
        end
        idle(4);
        for (int m = 0; m < 3; m++) begin
            chk("ovf_flag", m, 81'(o_ovf[m]), 81'(1));
            chk("ovf_count", m, 81'(o_cnt[m]), 81'(4));
        end
        idle(3);
        chk("head_stable", 1, 81'(o_tri[1][26:0]), 81'({9'd0, 9'd0, 9'd1}));
        rdy = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("drain_vld", 1, 81'(o_vld[1]), 81'(1));
            chk("drain_order", 1, 81'(o_tri[1][8:0]), 81'(i));
            idle(1);
        end
        chk("drain_empty", 1, 81'(o_vld[1]), 81'(0));
        obj_end(); idle(6);

        // Partial triangle at end-of-object, then a fresh one
        vtx(5, 5, 5); vtx(6, 6, 6);
        obj_end(); idle(6);
        for (int m = 0; m < 3; m++) chk("partial_set", m, 81'(o_part[m]), 81'(1));
        chk("partial_cnt", 1, 81'(o_cnt[1]), 81'(0));
        rdy = 1'b0;
        vtx(1, 1, 7); vtx(30, 1, 7); vtx(1, 30, 7);
        idle(2);
        chk("fresh_vld", 1, 81'(o_vld[1]), 81'(1));
        chk("fresh_v1", 1, 81'(o_tri[1][26:0]), 81'({9'd1, 9'd1, 9'd7}));
        chk("fresh_v3", 1, 81'(o_tri[1][80:54]), 81'({9'd1, 9'd30, 9'd7}));
        rdy = 1'b1;
        idle(2);
        obj_end(); idle(6);

        // Reset while draining with two queued triangles
        rdy = 1'b0;
        vtx(0, 0, 1); vtx(10, 0, 1); vtx(0, 10, 1);
        vtx(0, 0, 2); vtx(10, 0, 2); vtx(0, 10, 2);
        idle(4);
        obj_end();
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        for (int m = 0; m < 3; m++) begin
            chk("rst_mid_vld", m, 81'(o_vld[m]), 81'(0));
            chk("rst_mid_part", m, 81'(o_part[m]), 81'(0));
            chk("rst_mid_ovf", m, 81'(o_ovf[m]), 81'(0));
            chk("rst_mid_done", m, 81'(o_done[m]), 81'(0));
        end
        idle(5);

        // Random traffic
        repeat (3000) begin
            valid = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                xi = 9'($urandom_range(0, 3)); yi = 9'($urandom_range(0, 3));
            end else begin
                xi = 9'($urandom); yi = 9'($urandom);
            end
            zi  = 9'($urandom);
            rdy = ($urandom_range(0, 9) < 7);
            od  = ($urandom_range(0, 49) == 0);
            rst = ($urandom_range(0, 999) == 0);
            @(negedge clk);
        end
        valid = 1'b0; od = 1'b0; rst = 1'b0; rdy = 1'b1;
        idle(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tri_assembler.md
Name: tri_assembler

Overview:
- Sits between tri_proj and rasterizer.
- Groups the stream of projected screen-space vertices from tri_proj (x, y, z, 9 bits each, one per valid cycle) into triangles, in arrival order.
- Optionally culls degenerate or back-facing triangles.
- Buffers surviving triangles in a small FIFO and presents them to the rasterizer with a valid/ready handshake.
- Forwards end-of-object to the rasterizer only after the last triangle has been consumed.

Parameters:
- DEPTH, 4: triangle FIFO entries; power of two, 2..16.
- CULL_MODE, 1: 0 = no culling; 1 = cull zero-area triangles; 2 = cull zero-area and negative-area (clockwise) triangles.

Ports:
- clk_in  input  1  pixel clock
- rst_in  input  1  synchronous active-high reset
- valid_in  input  1  vertex strobe from tri_proj
- x_in  input  9  screen x
- y_in  input  9  screen y
- z_in  input  9  depth
- obj_done_in  input  1  one-cycle end-of-object pulse from tri_proj
- tri_ready_in  input  1  rasterizer accepts the current triangle
- vert1_out  output  3x9  vertex 1, indexed [2]=x, [1]=y, [0]=z
- vert2_out  output  3x9  vertex 2, same indexing
- vert3_out  output  3x9  vertex 3, same indexing
- valid_tri_out  output  1  FIFO head valid
- obj_done_out  output  1  one-cycle end-of-object pulse
- overflow_out  output  1  sticky: a triangle was dropped because the FIFO was full
- partial_out  output  1  sticky: obj_done_in arrived with 1 or 2 vertices pending
- tri_count_out  output  16  triangles enqueued since the last obj_done_out; wraps at 2^16

Behaviour:
Reset (one rst_in cycle, honoured at any point, including mid-triangle or mid-flush):
- All outputs go to 0.
- Vertex index goes to 0, FIFO is emptied, pipeline valids are cleared, FSM enters COLLECT.

Vertex collection:
- 2-bit index v_idx (0..2).
- Each valid_in latches {x, y, z} into slot v_idx.
- At v_idx=2 the three slots go to pipeline stage S1 and v_idx returns to 0. Otherwise v_idx increments.
- No back-pressure toward tri_proj: valid_in is always accepted.

Cull pipeline (2 stages):
- S1 registers the signed 10-bit differences dx2=x2-x1, dy2=y2-y1, dx3=x3-x1, dy3=y3-y1.
- S2 registers the signed 21-bit area = dx2*dy3 - dy2*dx3.
- Keep rule:
  - CULL_MODE=0: always keep.
  - CULL_MODE=1: keep iff area != 0.
  - CULL_MODE=2: keep iff area > 0.
- A kept triangle is written into the FIFO in the cycle after S2.
- Latency: 3rd vertex at cycle N means valid_tri_out is high at cycle N+3 if the FIFO was empty.

FIFO and handshake:
- Entry holds 81 bits.
- Pop when valid_tri_out && tri_ready_in.
- vert*_out show the head registers; they hold stable while valid_tri_out=1 and tri_ready_in=0.
- Write when full: the triangle is dropped, overflow_out is set, tri_count_out does not increment.
- Write and pop in the same cycle while full: the pop frees space and the write succeeds.
- tri_count_out increments on every successful write.

FSM, states COLLECT, FLUSH, DONE:
- COLLECT: on obj_done_in go to FLUSH.
  - If valid_in is high in the same cycle, that vertex is processed first.
  - If v_idx != 0 after that, discard the pending vertices, set v_idx=0 and set partial_out.
- FLUSH: stay until S1, S2 and the FIFO are all empty, then go to DONE.
  - valid_in during FLUSH is collected normally for the next object.
- DONE: obj_done_out=1 for exactly one cycle, tri_count_out clears, go to COLLECT.
  - A clear coincident with a write sets tri_count_out to 1.
- obj_done_in arriving while in FLUSH or DONE is latched and serviced on return to COLLECT.
- The sticky flags clear only on reset.

Decomposition:
- Package gfx_pkg:
  - typedef vertex_t (packed struct x, y, z, each logic[8:0])
  - typedef tri_t (vertex_t[2:0])
  - constants CULL_NONE=0, CULL_DEGEN=1, CULL_BACK=2
  - VTX_W=9
- Sub-module tri_fifo:
  - Parameterised synchronous FIFO of tri_t with full/empty flags and first-word-fall-through output.
  - Instantiated once.
- Cull arithmetic stays inline.

Test Plan:
1. CULL_MODE=1, ready held 1: vertices (20,20,30),(20,40,30),(40,20,30) on consecutive cycles, third at N -> valid_tri_out at N+3 with vert1_out=(20,20,30); tri_count_out=1. Then obj_done_in -> obj_done_out pulses once after the pop; tri_count_out returns to 0.
2. Collinear vertices (0,0,0),(10,10,0),(20,20,0) with CULL_MODE=1 -> no valid_tri_out and tri_count_out stays 0. The same triangle with CULL_MODE=0 -> enqueued.
3. CULL_MODE=2: (0,0,0),(0,10,0),(10,0,0) gives area -100 -> culled. Reversed order (0,0,0),(10,0,0),(0,10,0) gives +100 -> kept.
4. ready=0, DEPTH=4, 5 valid triangles -> 4 enqueued, overflow_out=1, tri_count_out=4, head stable. Raise ready -> 4 pops in order.
5. Two vertices then obj_done_in -> partial_out=1, no triangle emitted, obj_done_out pulses. A following 3-vertex triangle assembles correctly from v_idx=0.
6. rst_in asserted mid-FLUSH with 2 FIFO entries -> next cycle valid_tri_out=0, FIFO empty, no obj_done_out pulse, all flags 0.
